// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   tx_state_t   - transmitter FSM state encoding (ERR is an all-X don't-care
//                  used as the default next state for unreachable encodings)
//   DATA_BITS    - payload bits per frame
//   baud_cycles  - clocks per serial bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    BITS       = 3'd2,
    PARITY_BIT = 3'd3,
    STOP       = 3'd4,
    ACK        = 3'd5
  } tx_state_t;

  localparam tx_state_t ERR = tx_state_t'(3'bxxx);

  localparam int DATA_BITS = 8;

  function automatic int baud_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// baud_counter: mod-N counter that paces serial bit periods.
//   clk, reset - system clock, synchronous active-high reset
//   clr        - restart the count from zero on the next edge
//   done       - high during the terminal count (MOD_VALUE-1)
// Shared between the transmitter and the receiver.
module baud_counter #(
  parameter int MOD_VALUE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic done
);

  localparam int CNT_W = (MOD_VALUE > 1) ? $clog2(MOD_VALUE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD_VALUE - 1);

  logic [CNT_W-1:0] count;

  assign done = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: one asynchronous serial frame per debounced button press.
//   clk, reset - system clock, synchronous active-high reset
//   send       - debounced request level; a new frame needs send to drop first
//   din        - byte to transmit, captured only when a frame starts
//   tx_out     - registered serial line, idle-high
//   busy       - high from frame start until the FSM is back in IDLE
// Frame: start, 8 data bits LSB first, [parity], stop.
// Build option: define UART_TX_PARITY_EN to insert a parity bit
// (PARITY = 1 odd, 0 even); without it the frame is 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       busy
);

  localparam int BAUD_CYCLES = baud_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int BIT_CNT_W   = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  if (BAUD_CYCLES < 2 || (PARITY != 0 && PARITY != 1)) begin : g_bad_cfg
    $error("uart_tx: BAUD_CYCLES must be >= 2 and PARITY must be 0 or 1");
  end

  tx_state_t            state, next_state;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic                 tx_next, busy_next;
  logic                 baud_done, baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  baud_counter #(
    .MOD_VALUE(BAUD_CYCLES)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .done (baud_done)
  );

  always_comb begin
    next_state   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state)
      IDLE: begin
        if (send) begin
          next_state   = START;
          shift_next   = din;
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = (PARITY == 1) ? ~^din : ^din;
`endif
        end
      end
      START: if (baud_done) next_state = BITS;
      BITS: begin
        if (baud_done) begin
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            next_state   = PARITY_BIT;
`else
            next_state   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: if (baud_done) next_state = STOP;
`endif
      STOP: if (baud_done) next_state = ACK;
      ACK:  if (!send) next_state = IDLE;
      default: next_state = ERR;
    endcase

    // Every state change restarts the bit period from zero.
    baud_clr = (next_state != state);

    // Outputs decoded from the next state so the line register changes on
    // the same edge that the FSM enters a state.
    case (next_state)
      START: tx_next = 1'b0;
      BITS:  tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
    busy_next = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      shift_reg  <= shift_next;
      bit_cnt    <= bit_cnt_next;
      tx_out     <= tx_next;
      busy       <= busy_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a bit-level scoreboard.
// Expected line levels are queued when a frame is requested and popped as the
// serial line is sampled, one sample per clock on the falling edge.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BAUD = 10;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       send   = 1'b0;
  logic [7:0] din    = 8'h00;
  logic       tx_out;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  uart_tx #(
    .CLK_FREQUENCY(100),
    .BAUD_RATE    (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .send  (send),
    .din   (din),
    .tx_out(tx_out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(~^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Request a frame and check every clock of it. hold: sample index at which
  // send is dropped (0 = keep high). chg_at/chg_val: mid-frame din change.
  task automatic run_frame(input logic [7:0] d, input int hold,
                           input int chg_at, input logic [7:0] chg_val);
    logic b;
    int   k;
    din  = d;
    send = 1'b1;
    push_frame(d);
    k = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int c = 0; c < BAUD; c++) begin
        @(negedge clk);
        check("tx_bit", 8'(tx_out), 8'(b));
        if (c == 0) check("busy_frame", 8'(busy), 8'h01);
        k++;
        if (k == hold) send = 1'b0;
        if (k == chg_at) din = chg_val;
      end
    end
  endtask

  // send already low when STOP ends: one ACK cycle, then IDLE.
  task automatic ack_then_idle();
    @(negedge clk);
    check("ack_state", 8'(dut.state), 8'(ACK));
    check("ack_busy", 8'(busy), 8'h01);
    check("ack_tx", 8'(tx_out), 8'h01);
    @(negedge clk);
    check("idle_state", 8'(dut.state), 8'(IDLE));
    check("idle_busy", 8'(busy), 8'h00);
    check("idle_tx", 8'(tx_out), 8'h01);
  endtask

  initial begin
    // Reset with send high: reset wins.
    reset = 1'b1;
    send  = 1'b1;
    din   = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_tx", 8'(tx_out), 8'h01);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_state", 8'(dut.state), 8'(IDLE));
    check("rst_shift", dut.shift_reg, 8'h00);
    check("rst_bitcnt", 8'(dut.bit_cnt), 8'h00);
    send  = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 8'(tx_out), 8'h01);
    check("post_rst_busy", 8'(busy), 8'h00);

    // 0x55 with a one-cycle send pulse.
    run_frame(8'h55, 1, 0, 8'h00);
    ack_then_idle();

    // Held button: one frame, then ACK until send drops.
    run_frame(8'hA3, 0, 0, 8'h00);
    for (int i = 0; i < 300 - 10 * BAUD; i++) begin
      @(negedge clk);
      check("held_tx", 8'(tx_out), 8'h01);
      check("held_busy", 8'(busy), 8'h01);
      check("held_state", 8'(dut.state), 8'(ACK));
    end
    send = 1'b0;
    @(negedge clk);
    check("release_state", 8'(dut.state), 8'(IDLE));
    check("release_busy", 8'(busy), 8'h00);
    check("release_tx", 8'(tx_out), 8'h01);

    // din changes during data bit 2; latched 0x0F goes out.
    run_frame(8'h0F, 1, 35, 8'hF0);
    ack_then_idle();

    // Reset during data bit 3 of 0x5A.
    din  = 8'h5A;
    send = 1'b1;
    @(negedge clk);
    check("r_start", 8'(tx_out), 8'h00);
    send = 1'b0;
    repeat (44) @(negedge clk);
    check("r_bit3", 8'(tx_out), 8'h01);
    check("r_state", 8'(dut.state), 8'(BITS));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", 8'(tx_out), 8'h01);
    check("midrst_busy", 8'(busy), 8'h00);
    check("midrst_state", 8'(dut.state), 8'(IDLE));
    for (int i = 0; i < 3 * BAUD; i++) begin
      @(negedge clk);
      check("no_resume_tx", 8'(tx_out), 8'h01);
      check("no_resume_busy", 8'(busy), 8'h00);
    end
    run_frame(8'h5A, 1, 0, 8'h00);
    ack_then_idle();

`ifdef UART_TX_PARITY_EN
    // Odd parity: 0x07 -> 0, 0x03 -> 1; 11-bit frames.
    run_frame(8'h07, 1, 0, 8'h00);
    ack_then_idle();
    run_frame(8'h03, 1, 0, 8'h00);
    ack_then_idle();
`endif

    // Back-to-back: send rises one cycle after ACK exits.
    run_frame(8'h3C, 1, 0, 8'h00);
    ack_then_idle();
    run_frame(8'hC3, 1, 0, 8'h00);
    ack_then_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter stage that sits directly downstream of the debounced "send" button.
- Consumes the debounced level and the 8-bit switch value, and drives one asynchronous serial frame per button press on the tx line.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Holding the button sends exactly one frame. A new frame requires send to return low first.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate in bits/s.
- PARITY, 1: parity sense, used only when the optional feature is compiled in. 1 = odd, 0 = even.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- send  input  1  debounced request level from the debounce stage.
- din  input  8  byte to transmit; sampled only when a frame starts.
- tx_out  output  1  serial line, registered, idle-high.
- busy  output  1  high from frame start until the block returns to IDLE.

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values:
  - tx_out=1, busy=0, state=IDLE.
  - Baud counter and bit counter = 0.
  - Shift register = 0.
- Derived constant BAUD_CYCLES = CLK_FREQUENCY/BAUD_RATE (integer division).
  - Baud counter width = $clog2(BAUD_CYCLES).
  - The counter counts 0..BAUD_CYCLES-1; baud_done is asserted at the terminal count.
  - The counter is cleared on every state change.
- FSM states: IDLE, START, BITS, PARITY (feature only), STOP, ACK.
- IDLE:
  - tx_out=1, busy=0.
  - If send=1 at an edge: latch din into the shift register and go to START.
  - tx_out=0 and busy=1 from that same edge, so latency from send sampled to line falling is 1 cycle.
- START: tx_out=0 for exactly BAUD_CYCLES clocks, then go to BITS.
- BITS:
  - tx_out = shift_reg[0].
  - On each baud_done: shift right one bit and increment the bit counter.
  - After the 8th bit's baud_done: go to PARITY if compiled in, otherwise STOP.
  - Every bit lasts exactly BAUD_CYCLES clocks.
- STOP: tx_out=1 for BAUD_CYCLES clocks, then go to ACK.
- ACK:
  - tx_out=1, busy=1.
  - Stay while send=1. When send=0, go to IDLE on the next edge.
- Each output register is loaded from the next-state decode, so tx_out is glitch-free and aligned to state entry.
- Frame length is 10*BAUD_CYCLES clocks, or 11*BAUD_CYCLES with parity.
- Boundary conditions:
  - din changes mid-frame: ignored; only the latched copy is sent.
  - send toggles mid-frame: ignored; only IDLE and ACK sample send.
  - send already low at STOP exit: the block still passes through ACK for 1 cycle, then IDLE.
  - reset mid-frame: tx_out=1 and busy=0 on the next edge, FSM in IDLE. No partial frame resumes.
  - reset and send high in the same cycle: reset wins.
  - BAUD_CYCLES must be at least 2. This is checked by an elaboration-time assertion.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between BITS and STOP, lasting BAUD_CYCLES clocks.
  - The parity bit is computed from the latched byte at frame start.
  - Odd parity (PARITY=1): bit = ~^byte. Even parity (PARITY=0): bit = ^byte.
- Undefined: 8N1 frame only; PARITY state and parity logic are absent and the PARITY parameter is unused.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef tx_state_t, with an X-valued ERR default for synthesis don't-care;
  - the DATA_BITS=8 constant;
  - the function baud_cycles(clk_hz, baud).
- One natural sub-module, baud_counter. It is a mod-N counter with clr input and done output, parameterised by MOD_VALUE. It is reused by the receiver later.

Test Plan:
- Byte 0x55: CLK_FREQUENCY=100, BAUD_RATE=10 (BAUD_CYCLES=10), din=0x55, send pulse high.
  - tx_out falls 1 cycle later and then shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - Each level is held 10 clocks; busy stays high for at least 100 clocks.
- Held button: send held high for 300 clocks with din=0xA3.
  - Exactly one frame is sent; the block stays in ACK with busy=1 and tx_out=1 until send falls.
  - IDLE and busy=0 follow one cycle after send falls.
- Mid-frame din change: din=0x0F at start, changed to 0xF0 during bit 2.
  - The line carries data 1,1,1,1,0,0,0,0.
- Reset mid-frame: reset pulsed during data bit 3.
  - Next edge gives tx_out=1, busy=0, state IDLE.
  - A subsequent send produces a complete, correct frame.
- Parity (UART_TX_PARITY_EN, PARITY=1): din=0x07 gives parity bit 0; din=0x03 gives parity bit 1.
  - Frame length is 110 clocks in both cases.
- Back-to-back requests: send falls then rises 1 cycle after ACK exits.
  - A second frame starts; the line never shows a spurious low between frames.
